// File: rtl/rxdsp_spec_pkg.sv
// Shared definitions for the RX spectrum averager: combine modes, command field layout
// and lane geometry helpers.
package rxdsp_spec_pkg;

    typedef enum logic [1:0] {
        MODE_AVG = 2'd0,
        MODE_MAX = 2'd1,
        MODE_MIN = 2'd2
    } mode_e;

    localparam int CMD_MODE_LSB = 0;
    localparam int CMD_MODE_MSB = 1;
    localparam int CMD_K_LSB    = 4;
    localparam int CMD_K_MSB    = 7;
    localparam int K_W          = CMD_K_MSB - CMD_K_LSB + 1;

    function automatic int lanes(input int bin_width);
        return 64 / bin_width;
    endfunction

    function automatic int lane_log2(input int bin_width);
        return $clog2(64 / bin_width);
    endfunction

    function automatic int byte_log2(input int bin_width);
        return $clog2(bin_width / 8);
    endfunction

    // Encoding 3 is reserved and behaves as a plain average.
    function automatic mode_e decode_mode(input logic [1:0] code);
        case (code)
            2'd1:    return MODE_MAX;
            2'd2:    return MODE_MIN;
            default: return MODE_AVG;
        endcase
    endfunction

    function automatic logic [K_W-1:0] sat_k(input logic [K_W-1:0] k, input int k_max);
        if (int'(k) > k_max) return K_W'(k_max);
        return k;
    endfunction

endpackage

// File: rtl/rxdsp_spec_ram.sv
// Simple dual-port accumulator store: one write port, one registered read port.
module rxdsp_spec_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rxdsp_spec_avg.sv
// Spectrum post-processor: averages / max-holds / min-holds 2^K frames per bin and
// packs the fftshifted result into lane-addressed 64-bit buffer writes.
module rxdsp_spec_avg
    import rxdsp_spec_pkg::*;
#(
    parameter int FFT_LOG2         = 9,
    parameter int BIN_WIDTH        = 16,
    parameter int AVG_MAX_LOG2     = 8,
    parameter int BUFFER_SIZE_ADDR = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BUFFER_SIZE_ADDR-1:0] cfg_bsz,
    input  logic                        dspcmd_valid,
    output logic                        dspcmd_ready,
    input  logic [31:0]                 dspcmd_data,
    input  logic [BIN_WIDTH-1:0]        in_power,
    input  logic [FFT_LOG2-1:0]         in_index,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic [63:0]                 dsp_data,
    output logic                        dsp_valid,
    output logic [7:0]                  dsp_keep,
    output logic [BUFFER_SIZE_ADDR-4:0] dsp_waddr,
    output logic                        dsp_last,
    output logic                        stat_err
);

    localparam int LANES     = lanes(BIN_WIDTH);
    localparam int LANE_LOG2 = lane_log2(BIN_WIDTH);
    localparam int BYTES     = BIN_WIDTH / 8;
    localparam int ACC_W     = BIN_WIDTH + AVG_MAX_LOG2;
    localparam int NBINS     = 1 << FFT_LOG2;
    localparam int PKT_LSB   = FFT_LOG2 + byte_log2(BIN_WIDTH);
    localparam int PKT_W     = BUFFER_SIZE_ADDR - PKT_LSB;
    localparam int FCNT_W    = AVG_MAX_LOG2;
    localparam logic [7:0] LANE_MASK = 8'((1 << BYTES) - 1);

    logic                 cmd_pend;
    mode_e                cmd_mode;
    mode_e                act_mode;
    logic [K_W-1:0]       cmd_k;
    logic [K_W-1:0]       act_k;
    logic [FCNT_W-1:0]    fcnt;
    logic [FCNT_W-1:0]    fcnt_max;
    logic [FFT_LOG2-1:0]  bcnt;
    logic                 dropping;
    logic                 is_first;
    logic                 is_final;
    logic                 bcnt_full;
    logic                 accept;
    logic                 frame_err;

    logic                 s0_valid;
    logic                 s0_first;
    logic                 s0_final;
    logic                 s0_last;
    logic [BIN_WIDTH-1:0] s0_power;
    logic [FFT_LOG2-1:0]  s0_index;
    mode_e                s0_mode;
    logic [K_W-1:0]       s0_k;

    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_final;
    logic                 s1_last;
    logic [BIN_WIDTH-1:0] s1_power;
    logic [FFT_LOG2-1:0]  s1_index;
    mode_e                s1_mode;
    logic [K_W-1:0]       s1_k;

    logic [ACC_W-1:0]     ram_rd;
    logic [ACC_W-1:0]     power_ext;
    logic [ACC_W-1:0]     acc;
    logic [BIN_WIDTH-1:0] avg_val;
    logic [BIN_WIDTH-1:0] result;
    logic [FFT_LOG2-1:0]  sidx;
    logic                 emit;
    logic                 ram_we;
    logic                 pkt_wrap;
    logic [PKT_W-1:0]     pktoff;
    logic                 unused_bits;

    assign dspcmd_ready = 1'b1;
    assign unused_bits  = ^{dspcmd_data[31:CMD_K_MSB+1], dspcmd_data[CMD_K_LSB-1:CMD_MODE_MSB+1],
                            cfg_bsz[PKT_LSB-1:0]};

    assign fcnt_max  = FCNT_W'((1 << act_k) - 1);
    assign is_first  = (fcnt == '0);
    assign is_final  = (fcnt == fcnt_max);
    assign bcnt_full = (bcnt == FFT_LOG2'(NBINS - 1));
    assign accept    = in_valid && !dropping;
    assign frame_err = accept && (in_last ? !bcnt_full : bcnt_full);

    // Frame/bin counting and command hand-over; a pending command always wins on in_last.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_pend <= 1'b0;
            cmd_mode <= MODE_AVG;
            cmd_k    <= '0;
            act_mode <= MODE_AVG;
            act_k    <= '0;
            fcnt     <= '0;
            bcnt     <= '0;
            dropping <= 1'b0;
            stat_err <= 1'b0;
        end else begin
            if (in_valid && dropping) begin
                if (in_last) dropping <= 1'b0;
            end else if (in_valid) begin
                if (frame_err) begin
                    fcnt     <= '0;
                    bcnt     <= '0;
                    dropping <= !in_last;
                end else if (in_last) begin
                    bcnt <= '0;
                    fcnt <= is_final ? '0 : fcnt + 1'b1;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end

            if (in_valid && in_last && cmd_pend) begin
                act_mode <= cmd_mode;
                act_k    <= cmd_k;
                fcnt     <= '0;
                cmd_pend <= 1'b0;
            end

            if (dspcmd_valid) begin
                cmd_pend <= 1'b1;
                cmd_mode <= decode_mode(dspcmd_data[CMD_MODE_MSB:CMD_MODE_LSB]);
                cmd_k    <= sat_k(dspcmd_data[CMD_K_MSB:CMD_K_LSB], AVG_MAX_LOG2);
            end

            if (frame_err)         stat_err <= 1'b1;
            else if (dspcmd_valid) stat_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s0_valid <= accept;
            s1_valid <= s0_valid;
        end
    end

    // Each bin carries the config it was accepted under, so a switch never disturbs bins in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            s0_power <= in_power;
            s0_index <= in_index;
            s0_first <= is_first;
            s0_final <= is_final;
            s0_last  <= in_last;
            s0_mode  <= act_mode;
            s0_k     <= act_k;
        end
        s1_power <= s0_power;
        s1_index <= s0_index;
        s1_first <= s0_first;
        s1_final <= s0_final;
        s1_last  <= s0_last;
        s1_mode  <= s0_mode;
        s1_k     <= s0_k;
    end

    rxdsp_spec_ram #(
        .ADDR_W (FFT_LOG2),
        .DATA_W (ACC_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (s1_index),
        .wr_data (acc),
        .rd_addr (s0_index),
        .rd_data (ram_rd)
    );

    always_comb begin
        power_ext = ACC_W'(s1_power);
        acc       = power_ext;
        if (!s1_first) begin
            case (s1_mode)
                MODE_MAX: acc = (ram_rd > power_ext) ? ram_rd : power_ext;
                MODE_MIN: acc = (ram_rd < power_ext) ? ram_rd : power_ext;
                default:  acc = ram_rd + power_ext;
            endcase
        end
        avg_val = BIN_WIDTH'(acc >> s1_k);
        result  = (s1_mode == MODE_AVG) ? avg_val : acc[BIN_WIDTH-1:0];
    end

    // The final frame's sum is consumed directly; only K=0 still refreshes the store.
    assign ram_we   = s1_valid && (!s1_final || (s1_k == '0));
    assign emit     = s1_valid && s1_final;
    assign sidx     = s1_index ^ FFT_LOG2'(1 << (FFT_LOG2 - 1));
    assign pkt_wrap = (pktoff == cfg_bsz[BUFFER_SIZE_ADDR-1:PKT_LSB]);

    always_ff @(posedge clk) begin
        if (reset) begin
            dsp_valid <= 1'b0;
            dsp_last  <= 1'b0;
            pktoff    <= '0;
        end else begin
            dsp_valid <= emit;
            dsp_last  <= emit && s1_last && pkt_wrap;
            if (emit && s1_last) pktoff <= pkt_wrap ? '0 : pktoff + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (emit) begin
            dsp_data  <= {LANES{result}};
            dsp_keep  <= LANE_MASK << (BYTES * int'(sidx[LANE_LOG2-1:0]));
            dsp_waddr <= {pktoff, sidx[FFT_LOG2-1:LANE_LOG2]};
        end
    end

endmodule

// File: tb/tb_rxdsp_spec_avg.sv
// Directed bench for rxdsp_spec_avg at 512 bins x 16 bit; expectations are hand-derived per frame
// and checked cycle by cycle three cycles after each input.
module tb_rxdsp_spec_avg;

    localparam int PKT_LIMIT = 3;

    typedef struct packed {
        logic        valid;
        logic [15:0] bin;
        logic [15:0] data;
        logic [7:0]  keep;
        logic [12:0] waddr;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfg_bsz;
    logic        dspcmd_valid;
    logic        dspcmd_ready;
    logic [31:0] dspcmd_data;
    logic [15:0] in_power;
    logic [8:0]  in_index;
    logic        in_valid;
    logic        in_last;
    logic [63:0] dsp_data;
    logic        dsp_valid;
    logic [7:0]  dsp_keep;
    logic [12:0] dsp_waddr;
    logic        dsp_last;
    logic        stat_err;

    int   n_vec   = 0;
    int   n_err   = 0;
    int   exp_pkt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rxdsp_spec_avg #(
        .FFT_LOG2         (9),
        .BIN_WIDTH        (16),
        .AVG_MAX_LOG2     (8),
        .BUFFER_SIZE_ADDR (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_bsz      (cfg_bsz),
        .dspcmd_valid (dspcmd_valid),
        .dspcmd_ready (dspcmd_ready),
        .dspcmd_data  (dspcmd_data),
        .in_power     (in_power),
        .in_index     (in_index),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .dsp_data     (dsp_data),
        .dsp_valid    (dsp_valid),
        .dsp_keep     (dsp_keep),
        .dsp_waddr    (dsp_waddr),
        .dsp_last     (dsp_last),
        .stat_err     (stat_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus; outputs seen now belong to the input applied two calls earlier.
    task automatic applyStimulus(input logic v, input int pwr, input int idx, input logic last, input exp_t e);
        exp_t o;
        in_valid = v;
        in_power = 16'(pwr);
        in_index = 9'(idx);
        in_last  = last;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        dspcmd_valid = 1'b0;
        if (exp_q.size() == 3) begin
            o = exp_q.pop_front();
            checkOutput($sformatf("dsp_valid bin%0d", o.bin), 64'(dsp_valid), 64'(o.valid));
            if (o.valid) begin
                checkOutput($sformatf("dsp_data bin%0d", o.bin), dsp_data, {4{o.data}});
                checkOutput($sformatf("dsp_keep bin%0d", o.bin), 64'(dsp_keep), 64'(o.keep));
                checkOutput($sformatf("dsp_waddr bin%0d", o.bin), 64'(dsp_waddr), 64'(o.waddr));
                checkOutput($sformatf("dsp_last bin%0d", o.bin), 64'(dsp_last), 64'(o.last));
            end
        end
    endtask

    task automatic sendCmd(input logic [31:0] d);
        dspcmd_data  = d;
        dspcmd_valid = 1'b1;
        applyStimulus(1'b0, 0, 0, 1'b0, '0);
    endtask

    // pwr<0 sends a ramp (power=i); exp_val<0 expects the ramp back. sp_* override one bin.
    task automatic sendFrame(input int nbins, input int pwr, input int sp_idx, input int sp_pwr,
                             input bit emit, input int exp_val, input int sp_exp);
        exp_t e;
        int   p;
        int   x;
        int   s;
        for (int i = 0; i < nbins; i++) begin
            s = i ^ 256;
            p = (pwr < 0) ? i : ((i == sp_idx) ? sp_pwr : pwr);
            x = (exp_val < 0) ? i : ((i == sp_idx) ? sp_exp : exp_val);
            e.valid = emit;
            e.bin   = 16'(i);
            e.data  = 16'(x);
            e.keep  = 8'(3 << (2 * (s & 3)));
            e.waddr = 13'((exp_pkt << 7) | (s >> 2));
            e.last  = (i == nbins - 1) && (exp_pkt == PKT_LIMIT);
            applyStimulus(1'b1, p, i, i == nbins - 1, e);
        end
        if (emit) exp_pkt = (exp_pkt == PKT_LIMIT) ? 0 : exp_pkt + 1;
    endtask

    initial begin
        reset        = 1'b1;
        cfg_bsz      = 16'd4095;
        dspcmd_valid = 1'b0;
        dspcmd_data  = '0;
        in_power     = '0;
        in_index     = '0;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset dsp_valid", 64'(dsp_valid), 64'd0);
        checkOutput("reset dsp_last", 64'(dsp_last), 64'd0);
        checkOutput("reset stat_err", 64'(stat_err), 64'd0);
        checkOutput("dspcmd_ready", 64'(dspcmd_ready), 64'd1);
        reset = 1'b0;

        // Pass-through average after reset: ramp comes straight back, fftshifted.
        sendFrame(512, -1, -1, 0, 1'b1, -1, 0);
        sendFrame(512, -1, -1, 0, 1'b1, -1, 0);

        // K=2 average; the frame carrying the switch is still pass-through.
        sendCmd(32'h0000_0020);
        sendFrame(512, -1, -1, 0, 1'b1, -1, 0);
        sendFrame(512, 10, -1, 0, 1'b0, 0, 0);
        sendFrame(512, 20, -1, 0, 1'b0, 0, 0);
        sendFrame(512, 30, -1, 0, 1'b0, 0, 0);
        sendFrame(512, 41, -1, 0, 1'b1, 25, 0);

        // Max-hold K=1, entered via a discarded K=2 partial block.
        sendCmd(32'h0000_0011);
        sendFrame(512, 7, -1, 0, 1'b0, 0, 0);
        sendFrame(512, 50, 7, 100, 1'b0, 0, 0);
        sendFrame(512, 50, 7, 5, 1'b1, 50, 100);

        // Min-hold K=1, same stimulus.
        sendCmd(32'h0000_0012);
        sendFrame(512, 7, -1, 0, 1'b0, 0, 0);
        sendFrame(512, 50, 7, 100, 1'b0, 0, 0);
        sendFrame(512, 50, 7, 5, 1'b1, 50, 5);

        // Back to pass-through, then a 300-bin frame trips the sticky error.
        sendCmd(32'h0000_0000);
        sendFrame(512, 7, -1, 0, 1'b0, 0, 0);
        checkOutput("stat_err before short frame", 64'(stat_err), 64'd0);
        sendFrame(300, -1, -1, 0, 1'b1, -1, 0);
        checkOutput("stat_err after short frame", 64'(stat_err), 64'd1);
        sendFrame(512, -1, -1, 0, 1'b1, -1, 0);
        checkOutput("stat_err sticky", 64'(stat_err), 64'd1);
        sendCmd(32'h0000_0020);
        checkOutput("stat_err cleared by command", 64'(stat_err), 64'd0);

        // K=2 block interrupted after two frames by K=3; 8 clean frames follow: 108>>3 = 13.
        sendFrame(512, -1, -1, 0, 1'b1, -1, 0);
        sendFrame(512, 10, -1, 0, 1'b0, 0, 0);
        sendFrame(512, 10, -1, 0, 1'b0, 0, 0);
        sendCmd(32'h0000_0030);
        sendFrame(512, 10, -1, 0, 1'b0, 0, 0);
        for (int f = 0; f < 7; f++) sendFrame(512, 10 + f, -1, 0, 1'b0, 0, 0);
        sendFrame(512, 17, -1, 0, 1'b1, 13, 0);

        repeat (3) applyStimulus(1'b0, 0, 0, 1'b0, '0);
        checkOutput("stat_err at end", 64'(stat_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
